// File: rtl/decimal_score_entry.sv
// Two-digit decimal entry: collects tens and ones digits on strobes, encodes them
// to binary, range-checks the result and offers it over a valid/ready handshake.
module decimal_score_entry #(
  parameter int WIDTH     = 6,
  parameter int MAX_VALUE = 34
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [3:0]       digit_in,
  input  logic             digit_strobe,
  input  logic             clear,
  input  logic             value_ready,
  output logic [WIDTH-1:0] value_out,
  output logic             value_valid,
  output logic             error,
  output logic [3:0]       tens_digit,
  output logic [3:0]       ones_digit
);

  localparam int SUM_W = 7;

  typedef enum logic [2:0] {
    S_WAIT_TENS,
    S_WAIT_ONES,
    S_CALC,
    S_HOLD,
    S_ERR
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] value_nxt;
  logic             valid_nxt;
  logic             error_nxt;
  logic [3:0]       tens_nxt;
  logic [3:0]       ones_nxt;
  logic [SUM_W-1:0] sum_c;

  function automatic logic digit_ok(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

  // t*10 + o using shifts only; 9*10+9 = 99 fits in 7 bits
  function automatic logic [SUM_W-1:0] digits_to_bin(input logic [3:0] t,
                                                     input logic [3:0] o);
    logic [SUM_W-1:0] tw;
    logic [SUM_W-1:0] ow;
    tw = {3'b000, t};
    ow = {3'b000, o};
    return (tw << 3) + (tw << 1) + ow;
  endfunction

  function automatic logic sum_legal(input logic [SUM_W-1:0] s);
    logic [31:0] s_ext;
    s_ext = {{(32 - SUM_W){1'b0}}, s};
    return (s_ext <= MAX_VALUE);
  endfunction

  function automatic logic [WIDTH-1:0] fit_width(input logic [SUM_W-1:0] s);
    return WIDTH'(s);
  endfunction

  assign sum_c = digits_to_bin(tens_digit, ones_digit);

  always_comb begin
    state_nxt = state;
    value_nxt = value_out;
    valid_nxt = value_valid;
    error_nxt = error;
    tens_nxt  = tens_digit;
    ones_nxt  = ones_digit;

    if (clear) begin
      // abort wins over everything, including a same-cycle strobe or transfer
      state_nxt = S_WAIT_TENS;
      value_nxt = '0;
      valid_nxt = 1'b0;
      error_nxt = 1'b0;
      tens_nxt  = 4'd0;
      ones_nxt  = 4'd0;
    end else begin
      unique case (state)
        S_WAIT_TENS: begin
          if (digit_strobe) begin
            if (digit_ok(digit_in)) begin
              tens_nxt  = digit_in;
              state_nxt = S_WAIT_ONES;
            end else begin
              error_nxt = 1'b1;
              state_nxt = S_ERR;
            end
          end
        end
        S_WAIT_ONES: begin
          if (digit_strobe) begin
            if (digit_ok(digit_in)) begin
              ones_nxt  = digit_in;
              state_nxt = S_CALC;
            end else begin
              error_nxt = 1'b1;
              state_nxt = S_ERR;
            end
          end
        end
        S_CALC: begin
          if (sum_legal(sum_c)) begin
            value_nxt = fit_width(sum_c);
            valid_nxt = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            error_nxt = 1'b1;
            state_nxt = S_ERR;
          end
        end
        S_HOLD: begin
          // value_out stays frozen after the transfer until the next result
          if (value_ready) begin
            valid_nxt = 1'b0;
            tens_nxt  = 4'd0;
            ones_nxt  = 4'd0;
            state_nxt = S_WAIT_TENS;
          end
        end
        S_ERR: begin
          error_nxt = 1'b1;
        end
        default: begin
          state_nxt = S_WAIT_TENS;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= S_WAIT_TENS;
      value_out   <= '0;
      value_valid <= 1'b0;
      error       <= 1'b0;
      tens_digit  <= 4'd0;
      ones_digit  <= 4'd0;
    end else begin
      state       <= state_nxt;
      value_out   <= value_nxt;
      value_valid <= valid_nxt;
      error       <= error_nxt;
      tens_digit  <= tens_nxt;
      ones_digit  <= ones_nxt;
    end
  end

endmodule
